// File: rtl/dds_sine_core.sv
// Direct digital synthesis sine generator: phase accumulator, quarter-wave ROM
// with fold/negate symmetry, 3-stage enable-gated pipeline with valid tracking.
module dds_sine_core #(
  parameter int PHASE_W = 24,
  parameter int ADDR_W  = 8,
  parameter int OUT_W   = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic               sync_clr,
  input  logic [PHASE_W-1:0] fcw,
  input  logic               fcw_load,
  input  logic [ADDR_W-1:0]  phase_off,
  output logic [OUT_W-1:0]   sample,
  output logic               sample_valid
);

  localparam int Q   = 2 ** (ADDR_W - 2);
  localparam int AMP = 2 ** (OUT_W - 1) - 1;

  // Quarter-wave entry sampled at bin centres (k+0.5) so that the fold by bit
  // inversion is exactly symmetric; sine evaluated by Taylor series, x <= pi/2.
  function automatic int rom_value(input int k);
    real pi;
    real x;
    real term;
    real s;
    pi   = 3.14159265358979323846;
    x    = 2.0 * pi * (real'(k) + 0.5) / real'(2 ** ADDR_W);
    term = x;
    s    = x;
    for (int n = 1; n < 12; n++) begin
      term = -term * x * x / real'((2 * n) * (2 * n + 1));
      s    = s + term;
    end
    return $rtoi(real'(AMP) * s + 0.5);
  endfunction

  logic [OUT_W-2:0] rom [Q];

  for (genvar i = 0; i < Q; i++) begin : g_rom
    localparam int V = rom_value(i);
    assign rom[i] = (OUT_W-1)'(V);
  end

  logic [PHASE_W-1:0] fcw_reg;
  logic [PHASE_W-1:0] acc;
  logic [ADDR_W-1:0]  addr;
  logic [ADDR_W-3:0]  fold_idx;

  // Address uses the pre-increment accumulator.
  assign addr     = acc[PHASE_W-1 -: ADDR_W] + phase_off;
  assign fold_idx = addr[ADDR_W-2] ? ~addr[ADDR_W-3:0] : addr[ADDR_W-3:0];

  logic [ADDR_W-3:0] s1_idx;
  logic              s1_neg;
  logic [OUT_W-2:0]  s2_mag;
  logic              s2_neg;
  logic [2:0]        vld_sr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fcw_reg <= '0;
    end else if (fcw_load) begin
      fcw_reg <= fcw;
    end
  end

  // sync_clr wins over en; the whole datapath holds while en is low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc    <= '0;
      s1_idx <= '0;
      s1_neg <= 1'b0;
      s2_mag <= '0;
      s2_neg <= 1'b0;
      sample <= '0;
      vld_sr <= '0;
    end else if (sync_clr) begin
      acc    <= '0;
      s1_idx <= '0;
      s1_neg <= 1'b0;
      s2_mag <= '0;
      s2_neg <= 1'b0;
      sample <= '0;
      vld_sr <= '0;
    end else if (en) begin
      acc    <= acc + fcw_reg;
      s1_idx <= fold_idx;
      s1_neg <= addr[ADDR_W-1];
      s2_mag <= rom[s1_idx];
      s2_neg <= s1_neg;
      sample <= s2_neg ? -{1'b0, s2_mag} : {1'b0, s2_mag};
      vld_sr <= {vld_sr[1:0], 1'b1};
    end
  end

  assign sample_valid = vld_sr[2];

endmodule

// File: tb/tb_dds_sine_core.sv
// Bench for dds_sine_core: directed vector table, hand sequences for wrap,
// clear and mid-stream reset, and randomized traffic against a sine model.
module tb_dds_sine_core;
  localparam int PHASE_W = 24;
  localparam int ADDR_W  = 8;
  localparam int OUT_W   = 8;
  localparam int AMP     = 127;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               en;
  logic               sync_clr;
  logic [PHASE_W-1:0] fcw;
  logic               fcw_load;
  logic [ADDR_W-1:0]  phase_off;
  logic [OUT_W-1:0]   sample;
  logic               sample_valid;

  dds_sine_core #(.PHASE_W(PHASE_W), .ADDR_W(ADDR_W), .OUT_W(OUT_W)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .sync_clr(sync_clr), .fcw(fcw),
    .fcw_load(fcw_load), .phase_off(phase_off), .sample(sample),
    .sample_valid(sample_valid)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct { int a; int val; } item_t;
  item_t pend[$];
  logic [PHASE_W-1:0] m_acc;
  logic [PHASE_W-1:0] m_fcw;

  typedef struct {
    logic e; logic c; logic l; logic [PHASE_W-1:0] f; logic [ADDR_W-1:0] o;
    logic v; logic chk_s; int s;
  } vec_t;
  vec_t tbl[$];

  // Full-cycle sine at bin centre, rounded half away from zero.
  function automatic int ref_sine(input int a);
    real v;
    v = real'(AMP) * $sin(2.0 * 3.14159265358979323846 * (real'(a) + 0.5) / 256.0);
    if (v >= 0.0) return $rtoi(v + 0.5);
    else return -$rtoi(-v + 0.5);
  endfunction

  function automatic bit spec_val(input int a, output int v);
    spec_val = 1'b1;
    case (a)
      0:       v = 2;
      1:       v = 5;
      63:      v = 127;
      64:      v = 127;
      128:     v = -2;
      192:     v = -127;
      255:     v = -2;
      default: begin v = 0; spec_val = 1'b0; end
    endcase
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0; en = 1'b0; sync_clr = 1'b0; fcw_load = 1'b0;
    #2;
    check("reset_sample", int'($signed(sample)), 0);
    check("reset_valid", int'(sample_valid), 0);
    m_acc = '0; m_fcw = '0; pend.delete();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Called at a falling edge; applies inputs for one rising edge and checks.
  task automatic step(input logic e, input logic c, input logic l,
                      input logic [PHASE_W-1:0] f, input logic [ADDR_W-1:0] o);
    int  a;
    int  sv;
    logic exp_v;
    item_t it;
    en = e; sync_clr = c; fcw_load = l; fcw = f; phase_off = o;
    @(posedge clk);
    if (c) begin
      m_acc = '0;
      pend.delete();
    end else if (e) begin
      a = (int'(m_acc >> (PHASE_W - ADDR_W)) + int'(o)) % 256;
      it.a = a; it.val = ref_sine(a);
      pend.push_back(it);
      if (pend.size() > 3) void'(pend.pop_front());
      m_acc = m_acc + m_fcw;
    end
    if (l) m_fcw = f;
    @(negedge clk);
    exp_v = (pend.size() == 3);
    check("valid", int'(sample_valid), int'(exp_v));
    if (exp_v) begin
      check("sample", int'($signed(sample)), pend[0].val);
      if (spec_val(pend[0].a, sv)) check("spec_sample", int'($signed(sample)), sv);
    end else if (pend.size() == 0) begin
      check("sample_zero", int'($signed(sample)), 0);
    end
  endtask

  initial begin
    rst_n = 1'b1; en = 1'b0; sync_clr = 1'b0; fcw_load = 1'b0;
    fcw = '0; phase_off = '0;
    @(negedge clk);

    // Continuous run, fcw = 65536: a steps 0,1,2,... one per enabled edge.
    do_reset();
    step(1'b0, 1'b0, 1'b1, 24'd65536, 8'd0);
    for (int i = 1; i <= 260; i++) begin
      step(1'b1, 1'b0, 1'b0, 24'd0, 8'd0);
      if (i == 2) check("first_valid_low", int'(sample_valid), 0);
      if (i == 3) begin
        check("first_valid_high", int'(sample_valid), 1);
        check("first_sample", int'($signed(sample)), 2);
      end
      if (i == 4) check("second_sample", int'($signed(sample)), 5);
    end

    // Same stream with en toggling; stalls hold the output.
    do_reset();
    step(1'b0, 1'b0, 1'b1, 24'd65536, 8'd0);
    for (int i = 0; i < 520; i++) step(i % 2 == 0, 1'b0, 1'b0, 24'd0, 8'd0);

    // Directed vector table: half-rate tone, constant phase offsets, clear+load.
    do_reset();
    tbl.push_back('{1'b0, 1'b0, 1'b1, 24'h800000, 8'd0,   1'b0, 1'b1, 0});
    tbl.push_back('{1'b1, 1'b0, 1'b0, 24'h0,     8'd0,   1'b0, 1'b0, 0});
    tbl.push_back('{1'b1, 1'b0, 1'b0, 24'h0,     8'd0,   1'b0, 1'b0, 0});
    tbl.push_back('{1'b1, 1'b0, 1'b0, 24'h0,     8'd0,   1'b1, 1'b1, 2});
    tbl.push_back('{1'b1, 1'b0, 1'b0, 24'h0,     8'd0,   1'b1, 1'b1, -2});
    tbl.push_back('{1'b0, 1'b0, 1'b0, 24'h0,     8'd0,   1'b1, 1'b1, -2});
    tbl.push_back('{1'b1, 1'b0, 1'b0, 24'h0,     8'd0,   1'b1, 1'b1, 2});
    tbl.push_back('{1'b1, 1'b0, 1'b0, 24'h0,     8'd0,   1'b1, 1'b1, -2});
    tbl.push_back('{1'b1, 1'b1, 1'b1, 24'h0,     8'd64,  1'b0, 1'b1, 0});
    tbl.push_back('{1'b1, 1'b0, 1'b0, 24'h0,     8'd64,  1'b0, 1'b0, 0});
    tbl.push_back('{1'b1, 1'b0, 1'b0, 24'h0,     8'd64,  1'b0, 1'b0, 0});
    tbl.push_back('{1'b1, 1'b0, 1'b0, 24'h0,     8'd64,  1'b1, 1'b1, 127});
    tbl.push_back('{1'b1, 1'b0, 1'b0, 24'h0,     8'd64,  1'b1, 1'b1, 127});
    tbl.push_back('{1'b1, 1'b0, 1'b0, 24'h0,     8'd192, 1'b1, 1'b1, 127});
    tbl.push_back('{1'b1, 1'b0, 1'b0, 24'h0,     8'd192, 1'b1, 1'b1, 127});
    tbl.push_back('{1'b1, 1'b0, 1'b0, 24'h0,     8'd192, 1'b1, 1'b1, -127});
    tbl.push_back('{1'b1, 1'b0, 1'b0, 24'h0,     8'd192, 1'b1, 1'b1, -127});
    tbl.push_back('{1'b1, 1'b1, 1'b1, 24'd65536, 8'd0,   1'b0, 1'b1, 0});
    tbl.push_back('{1'b1, 1'b0, 1'b0, 24'h0,     8'd0,   1'b0, 1'b0, 0});
    tbl.push_back('{1'b1, 1'b0, 1'b0, 24'h0,     8'd0,   1'b0, 1'b0, 0});
    tbl.push_back('{1'b1, 1'b0, 1'b0, 24'h0,     8'd0,   1'b1, 1'b1, 2});
    tbl.push_back('{1'b1, 1'b0, 1'b0, 24'h0,     8'd0,   1'b1, 1'b1, 5});
    tbl.push_back('{1'b1, 1'b0, 1'b0, 24'h0,     8'd0,   1'b1, 1'b1, 8});
    foreach (tbl[i]) begin
      step(tbl[i].e, tbl[i].c, tbl[i].l, tbl[i].f, tbl[i].o);
      check($sformatf("tbl%0d_valid", i), int'(sample_valid), int'(tbl[i].v));
      if (tbl[i].chk_s) check($sformatf("tbl%0d_sample", i), int'($signed(sample)), tbl[i].s);
    end

    // Accumulator wrap: acc 0xFFFF00 + 0x200 -> 0x000100, a goes 255 -> 0.
    step(1'b1, 1'b1, 1'b1, 24'hFFFF00, 8'd0);
    step(1'b1, 1'b0, 1'b1, 24'h000200, 8'd0);
    step(1'b1, 1'b0, 1'b0, 24'h0, 8'd0);
    step(1'b1, 1'b0, 1'b0, 24'h0, 8'd0);
    check("wrap_first", int'($signed(sample)), 2);
    step(1'b1, 1'b0, 1'b0, 24'h0, 8'd0);
    check("wrap_a255", int'($signed(sample)), -2);
    step(1'b1, 1'b0, 1'b0, 24'h0, 8'd0);
    check("wrap_a0", int'($signed(sample)), 2);

    // Mid-stream asynchronous reset must abort the pipeline.
    step(1'b1, 1'b0, 1'b1, 24'h123456, 8'd17);
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b0, 24'h0, 8'd17);
    do_reset();
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 1'b0, 1'b0, 24'h0, 8'd17);
      if (i == 1) check("post_reset_no_stale", int'(sample_valid), 0);
    end

    // Randomized traffic against the model.
    for (int i = 0; i < 4000; i++) begin
      logic e, c, l;
      logic [PHASE_W-1:0] f;
      logic [ADDR_W-1:0]  o;
      e = ($urandom_range(0, 3) != 0);
      c = ($urandom_range(0, 79) == 0);
      l = ($urandom_range(0, 19) == 0);
      f = ($urandom_range(0, 1) == 0) ? PHASE_W'($urandom) : PHASE_W'($urandom_range(0, 2 ** 18));
      o = ($urandom_range(0, 29) == 0) ? ADDR_W'($urandom) : phase_off;
      step(e, c, l, f, o);
      if ($urandom_range(0, 999) == 0) do_reset();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
